// File: rtl/mux_sp_nch.sv
// Channel-tagged serial samples are steered into per-channel FIFOs and leave as aligned NUM_CH-wide frames every OUT_DIV clocks.
// Build option: define MUX_SP_ROUND_EN for round-half-up with saturation when narrowing (adds one read-side stage).
module mux_sp_nch #(
  parameter int INPUT_WIDTH  = 24,
  parameter int OUTPUT_WIDTH = 24,
  parameter int NUM_CH       = 2,
  parameter int CH_IDX_W     = 4,
  parameter int FIFO_AW      = 4,
  parameter int START_LEVEL  = 8,
  parameter int OUT_DIV      = 8
) (
  input  logic                           CLK,
  input  logic                           nRST,
  input  logic [INPUT_WIDTH-1:0]         Data_In,
  input  logic                           Data_In_Valid,
  input  logic [CH_IDX_W-1:0]            Data_In_ChIdx,
  input  logic                           Flag_Clr,
  output logic [NUM_CH*OUTPUT_WIDTH-1:0] Data_Out,
  output logic                           Data_Out_Valid,
  output logic                           Running,
  output logic [NUM_CH-1:0]              Ovf_Flag,
  output logic                           Udf_Flag,
  output logic                           ChIdx_Err
);

`ifdef MUX_SP_ROUND_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif
  localparam bit PIPE = ROUND_EN && (OUTPUT_WIDTH < INPUT_WIDTH);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = $clog2(OUT_DIV);
  localparam logic [FIFO_AW:0] DEPTH_W   = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0] START_W   = (FIFO_AW+1)'(START_LEVEL);
  localparam logic [FIFO_AW:0] USED_ZERO = {(FIFO_AW+1){1'b0}};
  localparam logic [CW-1:0]    CNT_LOAD  = CW'(OUT_DIV - 1);
  localparam logic [CW-1:0]    CNT_ZERO  = {CW{1'b0}};
  localparam logic [0:0]       S_FILL    = 1'b0;
  localparam logic [0:0]       S_RUN     = 1'b1;

  logic [INPUT_WIDTH-1:0]  mem_q [NUM_CH][DEPTH];
  logic [FIFO_AW-1:0]      wr_ptr_q [NUM_CH], wr_ptr_d [NUM_CH];
  logic [FIFO_AW-1:0]      rd_ptr_q [NUM_CH], rd_ptr_d [NUM_CH];
  logic [FIFO_AW:0]        usedw_q [NUM_CH], usedw_d [NUM_CH];
  logic [0:0]              state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [NUM_CH-1:0]       ovf_q, ovf_d, ovf_set_s, hit_s, wr_en_s;
  logic                    udf_q, udf_d, udf_set_s, err_q, err_d, err_set_s;
  logic                    all_ge_s, all_ne_s, pop_s;
  logic                    stg_valid_q, stg_valid_d, src_valid_s, valid_q, valid_d;
  logic [INPUT_WIDTH-1:0]  stg_data_q [NUM_CH], stg_data_d [NUM_CH];
  logic [INPUT_WIDTH-1:0]  rd_data_s [NUM_CH], src_data_s [NUM_CH];
  logic [NUM_CH*OUTPUT_WIDTH-1:0] conv_flat_s, data_out_q, data_out_d;

  // Fill-level summary across all channels
  always_comb begin
    all_ge_s = 1'b1;
    all_ne_s = 1'b1;
    for (int k = 0; k < NUM_CH; k++) begin
      all_ge_s = all_ge_s & (usedw_q[k] >= START_W);
      all_ne_s = all_ne_s & (usedw_q[k] != USED_ZERO);
    end
  end

  // Fill/run sequencer; a due slot with any FIFO empty aborts rather than emitting a partial frame
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pop_s     = 1'b0;
    udf_set_s = 1'b0;
    case (state_q)
      S_FILL: begin
        if (all_ge_s) begin
          state_d = S_RUN;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = S_FILL;
        end
      end
      S_RUN: begin
        if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CW'(1);
        end else if (all_ne_s) begin
          pop_s = 1'b1;
          cnt_d = CNT_LOAD;
        end else begin
          udf_set_s = 1'b1;
          state_d   = S_FILL;
        end
      end
      default: begin
        state_d = S_FILL;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Write steering and pointer/occupancy bookkeeping; fullness is judged before this cycle's pop
  always_comb begin
    hit_s     = {NUM_CH{1'b0}};
    wr_en_s   = {NUM_CH{1'b0}};
    ovf_set_s = {NUM_CH{1'b0}};
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    usedw_d   = usedw_q;
    err_set_s = Data_In_Valid & (int'(Data_In_ChIdx) >= NUM_CH);
    for (int k = 0; k < NUM_CH; k++) begin
      hit_s[k]     = Data_In_Valid & (Data_In_ChIdx == CH_IDX_W'(k));
      wr_en_s[k]   = hit_s[k] & (usedw_q[k] != DEPTH_W);
      ovf_set_s[k] = hit_s[k] & (usedw_q[k] == DEPTH_W);
      wr_ptr_d[k]  = wr_en_s[k] ? wr_ptr_q[k] + FIFO_AW'(1) : wr_ptr_q[k];
      rd_ptr_d[k]  = pop_s ? rd_ptr_q[k] + FIFO_AW'(1) : rd_ptr_q[k];
      case ({wr_en_s[k], pop_s})
        2'b10:   usedw_d[k] = usedw_q[k] + (FIFO_AW+1)'(1);
        2'b01:   usedw_d[k] = usedw_q[k] - (FIFO_AW+1)'(1);
        default: usedw_d[k] = usedw_q[k];
      endcase
    end
    ovf_d = (Flag_Clr ? {NUM_CH{1'b0}} : ovf_q) | ovf_set_s;
    udf_d = (Flag_Clr ? 1'b0 : udf_q) | udf_set_s;
    err_d = (Flag_Clr ? 1'b0 : err_q) | err_set_s;
  end

  // Read port and optional stage ahead of the rounding logic
  always_comb begin
    stg_valid_d = pop_s;
    stg_data_d  = stg_data_q;
    rd_data_s   = stg_data_q;
    src_data_s  = stg_data_q;
    for (int k = 0; k < NUM_CH; k++) begin
      rd_data_s[k]  = mem_q[k][rd_ptr_q[k]];
      stg_data_d[k] = pop_s ? rd_data_s[k] : stg_data_q[k];
      src_data_s[k] = PIPE ? stg_data_q[k] : rd_data_s[k];
    end
    src_valid_s = PIPE ? stg_valid_q : pop_s;
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_conv
    if (OUTPUT_WIDTH >= INPUT_WIDTH) begin : g_ext
      assign conv_flat_s[k*OUTPUT_WIDTH +: OUTPUT_WIDTH] = OUTPUT_WIDTH'($signed(src_data_s[k]));
    end else if (PIPE) begin : g_rnd
      logic [INPUT_WIDTH:0]    rnd_s;
      logic [OUTPUT_WIDTH:0]   shr_s;
      logic [OUTPUT_WIDTH-1:0] sat_s;
      // Round half up, then clamp when the extra integer bit disagrees with the sign
      always_comb begin
        rnd_s = {src_data_s[k][INPUT_WIDTH-1], src_data_s[k]}
              + ((INPUT_WIDTH+1)'(1) << (INPUT_WIDTH-OUTPUT_WIDTH-1));
        shr_s = (OUTPUT_WIDTH+1)'(rnd_s >> (INPUT_WIDTH-OUTPUT_WIDTH));
        if (shr_s[OUTPUT_WIDTH] != shr_s[OUTPUT_WIDTH-1]) begin
          sat_s = shr_s[OUTPUT_WIDTH] ? {1'b1, {(OUTPUT_WIDTH-1){1'b0}}}
                                      : {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
        end else begin
          sat_s = shr_s[OUTPUT_WIDTH-1:0];
        end
      end
      assign conv_flat_s[k*OUTPUT_WIDTH +: OUTPUT_WIDTH] = sat_s;
    end else begin : g_trunc
      assign conv_flat_s[k*OUTPUT_WIDTH +: OUTPUT_WIDTH] =
        OUTPUT_WIDTH'(src_data_s[k] >> (INPUT_WIDTH-OUTPUT_WIDTH));
    end
  end

  // Output frame register holds between strobes
  always_comb begin
    valid_d = src_valid_s;
    if (src_valid_s) begin
      data_out_d = conv_flat_s;
    end else begin
      data_out_d = data_out_q;
    end
  end

  // Sample storage; contents need no reset since pointers define validity
  always_ff @(posedge CLK) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (nRST && wr_en_s[k]) begin
        mem_q[k][wr_ptr_q[k]] <= Data_In;
      end
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int k = 0; k < NUM_CH; k++) begin
        wr_ptr_q[k]   <= {FIFO_AW{1'b0}};
        rd_ptr_q[k]   <= {FIFO_AW{1'b0}};
        usedw_q[k]    <= USED_ZERO;
        stg_data_q[k] <= {INPUT_WIDTH{1'b0}};
      end
      state_q     <= S_FILL;
      cnt_q       <= CNT_ZERO;
      ovf_q       <= {NUM_CH{1'b0}};
      udf_q       <= 1'b0;
      err_q       <= 1'b0;
      stg_valid_q <= 1'b0;
      valid_q     <= 1'b0;
      data_out_q  <= {(NUM_CH*OUTPUT_WIDTH){1'b0}};
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      usedw_q     <= usedw_d;
      stg_data_q  <= stg_data_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
      err_q       <= err_d;
      stg_valid_q <= stg_valid_d;
      valid_q     <= valid_d;
      data_out_q  <= data_out_d;
    end
  end

  assign Data_Out       = data_out_q;
  assign Data_Out_Valid = valid_q;
  assign Running        = (state_q == S_RUN);
  assign Ovf_Flag       = ovf_q;
  assign Udf_Flag       = udf_q;
  assign ChIdx_Err      = err_q;

endmodule

// File: tb/tb_mux_sp_nch.sv
// Bench for mux_sp_nch (24->16 bit, 2 channels): queue-based reference model checked every cycle, plus directed sequences.
module tb_mux_sp_nch;
  localparam int IW = 24, OW = 16, NC = 2, SL = 8, OD = 8, DEPTH = 16;
`ifdef MUX_SP_ROUND_EN
  localparam bit RND = 1'b1;
  localparam int LAT = 2;
`else
  localparam bit RND = 1'b0;
  localparam int LAT = 1;
`endif

  logic clk, nrst, din_valid, flag_clr;
  logic [IW-1:0] din;
  logic [3:0] din_idx;
  logic [NC*OW-1:0] dout;
  logic dout_valid, running, udf, chidx_err;
  logic [NC-1:0] ovf;
  int checks = 0, errors = 0;

  mux_sp_nch #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .NUM_CH(NC), .CH_IDX_W(4),
               .FIFO_AW(4), .START_LEVEL(SL), .OUT_DIV(OD)) dut (
    .CLK(clk), .nRST(nrst), .Data_In(din), .Data_In_Valid(din_valid),
    .Data_In_ChIdx(din_idx), .Flag_Clr(flag_clr), .Data_Out(dout),
    .Data_Out_Valid(dout_valid), .Running(running), .Ovf_Flag(ovf),
    .Udf_Flag(udf), .ChIdx_Err(chidx_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic view of the width rule
  function automatic logic [OW-1:0] ref_conv(input logic [IW-1:0] s);
    int v, r;
    v = $signed(s);
    if (RND) begin
      r = (v + 128) >>> 8;
      if (r > 32767) r = 32767;
      else if (r < -32768) r = -32768;
    end else begin
      r = v >>> 8;
    end
    return OW'(r);
  endfunction

  // Reference model: queues per channel, frame slots counted in clocks
  int mq [NC][$];
  int sz [NC];
  bit m_run, m_valid, p_valid, armed, popped, us, es;
  int m_cnt, id;
  logic [NC-1:0] m_ovf, ovs;
  bit m_udf, m_err;
  logic [NC*OW-1:0] m_dout, p_data, frame;

  always @(posedge clk) begin
    if (!nrst) begin
      for (int k = 0; k < NC; k++) mq[k].delete();
      m_run = 0; m_cnt = 0; m_ovf = '0; m_udf = 0; m_err = 0;
      m_dout = '0; m_valid = 0; p_valid = 0; p_data = '0; armed = 1;
    end else begin
      for (int k = 0; k < NC; k++) sz[k] = mq[k].size();
      popped = 0; us = 0; es = 0; ovs = '0; frame = '0;
      if (!m_run) begin
        if (sz[0] >= SL && sz[1] >= SL) begin m_run = 1; m_cnt = 0; end
      end else if (m_cnt > 0) begin
        m_cnt--;
      end else if (sz[0] > 0 && sz[1] > 0) begin
        popped = 1;
        for (int k = 0; k < NC; k++) frame[k*OW +: OW] = ref_conv(IW'(mq[k].pop_front()));
        m_cnt = OD - 1;
      end else begin
        us = 1; m_run = 0;
      end
      if (din_valid) begin
        id = din_idx;
        if (id >= NC) es = 1;
        else if (sz[id] >= DEPTH) ovs[id] = 1'b1;
        else mq[id].push_back(int'(din));
      end
      m_ovf = (flag_clr ? '0 : m_ovf) | ovs;
      m_udf = (flag_clr ? 1'b0 : m_udf) | us;
      m_err = (flag_clr ? 1'b0 : m_err) | es;
      if (LAT == 1) begin
        m_valid = popped;
        if (popped) m_dout = frame;
      end else begin
        m_valid = p_valid;
        if (p_valid) m_dout = p_data;
        p_valid = popped;
        if (popped) p_data = frame;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("m_valid", dout_valid, m_valid);
      check("m_dout", dout, m_dout);
      check("m_running", running, m_run);
      check("m_ovf", ovf, m_ovf);
      check("m_udf", udf, m_udf);
      check("m_err", chidx_err, m_err);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic wr(input int ch, input logic [IW-1:0] d);
    din_valid = 1'b1; din_idx = 4'(ch); din = d;
    tick();
    din_valid = 1'b0;
  endtask
  task automatic do_reset();
    nrst = 1'b0; tick(); nrst = 1'b1;
  endtask
  task automatic wait_frames(input int n, input int budget, output int got);
    got = 0;
    for (int c = 0; c < budget && got < n; c++) begin
      @(negedge clk);
      if (dout_valid) got++;
    end
  endtask

  typedef struct { logic [IW-1:0] din; logic [OW-1:0] exp_tr; logic [OW-1:0] exp_rd; } vec_t;
  vec_t vecs [7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nfr, last, got, r, p;
    logic [OW-1:0] e;
    vecs[0] = '{24'h7FFF80, 16'h7FFF, 16'h7FFF};
    vecs[1] = '{24'h000180, 16'h0001, 16'h0002};
    vecs[2] = '{24'hFFFF80, 16'hFFFF, 16'h0000};
    vecs[3] = '{24'h800000, 16'h8000, 16'h8000};
    vecs[4] = '{24'h1234C0, 16'h1234, 16'h1235};
    vecs[5] = '{24'hFFFE7F, 16'hFFFE, 16'hFFFE};
    vecs[6] = '{24'h7FFF7F, 16'h7FFF, 16'h7FFF};

    nrst = 1'b0; din_valid = 1'b0; din_idx = 4'd0; din = 24'd0; flag_clr = 1'b0;
    tick(); tick(); nrst = 1'b1;
    @(negedge clk);
    check("rst_dout", dout, 32'd0);
    check("rst_valid", dout_valid, 1'b0);
    check("rst_running", running, 1'b0);
    check("rst_flags", {ovf, udf, chidx_err}, 4'd0);

    // Interleaved I=k, Q=-k frames
    for (int k = 1; k <= 8; k++) begin
      wr(0, IW'(k * 256));
      wr(1, IW'(-k * 256));
    end
    @(negedge clk); check("run_not_yet", running, 1'b0);
    @(negedge clk); check("run_rise", running, 1'b1);
    nfr = 0; last = -1;
    for (int c = 0; c < 100 && nfr < 8; c++) begin
      @(negedge clk);
      if (dout_valid) begin
        nfr++;
        check("frame_data", dout, {16'(-nfr), 16'(nfr)});
        if (last >= 0) check("frame_gap", c - last, 8);
        last = c;
      end
    end
    check("frame_count", nfr, 8);

    // Overflow on channel 0 with channel 1 empty
    do_reset();
    for (int i = 0; i < 17; i++) wr(0, IW'(i + 1));
    @(negedge clk); check("ovf_set", ovf, 2'b01);
    flag_clr = 1'b1; tick(); flag_clr = 1'b0;
    @(negedge clk); check("ovf_clr", ovf, 2'b00);

    // Underrun when channel 1 stops
    do_reset();
    for (int k = 0; k < 8; k++) begin wr(0, IW'($urandom)); wr(1, IW'($urandom)); end
    for (int c = 0; c < 200 && !udf; c++) begin
      if (c % 8 == 0) wr(0, IW'($urandom)); else tick();
    end
    @(negedge clk);
    check("udf_set", udf, 1'b1);
    check("udf_stop", running, 1'b0);
    for (int k = 0; k < 8; k++) begin wr(0, IW'($urandom)); wr(1, IW'($urandom)); end
    wait_frames(1, 40, got);
    check("udf_resume", got, 1);

    // Out-of-range channel index
    do_reset();
    for (int k = 0; k < 8; k++) wr(0, IW'(k));
    for (int k = 0; k < 7; k++) wr(1, IW'(k));
    wr(5, 24'h00ABCD);
    @(negedge clk); check("chidx_err", chidx_err, 1'b1);
    for (int c = 0; c < 4; c++) @(negedge clk);
    check("chidx_nowrite", running, 1'b0);

    // Width rule vectors
    for (int i = 0; i < 7; i++) begin
      do_reset();
      for (int k = 0; k < 8; k++) begin wr(0, vecs[i].din); wr(1, vecs[i].din); end
      wait_frames(1, 40, got);
      e = RND ? vecs[i].exp_rd : vecs[i].exp_tr;
      check("width_seen", got, 1);
      check("width_ch0", dout[OW-1:0], e);
      check("width_ch1", dout[2*OW-1:OW], e);
    end

    // Mid-run reset with five samples left per FIFO
    do_reset();
    for (int k = 0; k < 8; k++) begin wr(0, IW'($urandom)); wr(1, IW'($urandom)); end
    wait_frames(3, 60, got);
    check("mid_frames", got, 3);
    nrst = 1'b0; tick(); nrst = 1'b1;
    @(negedge clk);
    check("mid_dout", dout, 32'd0);
    check("mid_valid", dout_valid, 1'b0);
    check("mid_running", running, 1'b0);
    wait_frames(1, 30, got);
    check("mid_noframe", got, 0);

    // Randomized traffic against the model
    do_reset();
    for (int seg = 0; seg < 6; seg++) begin
      p = 10 + (seg * 13) % 60;
      for (int c = 0; c < 500; c++) begin
        nrst = ($urandom_range(0, 399) != 0);
        din_valid = ($urandom_range(0, 99) < p);
        r = $urandom_range(0, 15);
        din_idx = (r < 7) ? 4'd0 : (r < 14) ? 4'd1 : 4'($urandom_range(2, 15));
        din = IW'($urandom);
        flag_clr = ($urandom_range(0, 49) == 0);
        tick();
      end
    end
    nrst = 1'b1; din_valid = 1'b0; flag_clr = 1'b0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
